noc_mem_responder: RTL and testbench

// - Clocked memory-side endpoint of the 3x3 NoC. Sits behind the memory port of the memory-wrapper router (node 4'b1101).
// - Receives request packets over a 4-phase bundled-data channel and performs the access on a synchronous SRAM port.
// - Returns read-data / write-ack packets to the source node over a second 4-phase channel.

---
 rtl/noc_mem_responder_pkg.sv | 64 ++++++
 rtl/noc_mem_responder_hs4_tx.sv | 51 +++++
 rtl/noc_mem_responder.sv | 122 ++++++++++++
 tb/tb_noc_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mem_responder_pkg.sv
// Shared NoC definitions: packet field map, opcodes, node addresses, packet
// struct and the FSM state types used by the memory responder.
package noc_mem_responder_pkg;

    localparam int unsigned PKT_W   = 33;
    localparam int unsigned DEST_HI = 32;
    localparam int unsigned DEST_LO = 29;
    localparam int unsigned SRC_HI  = 28;
    localparam int unsigned SRC_LO  = 25;
    localparam int unsigned OP_HI   = 24;
    localparam int unsigned OP_LO   = 23;
    localparam int unsigned ADDR_HI = 22;
    localparam int unsigned ADDR_LO = 16;
    localparam int unsigned DATA_HI = 15;
    localparam int unsigned DATA_LO = 0;

    localparam logic [3:0] MEM_NODE = 4'b1101;
    localparam logic [3:0] PE0      = 4'h0;
    localparam logic [3:0] PE1      = 4'h1;
    localparam logic [3:0] PE2      = 4'h2;
    localparam logic [3:0] PE3      = 4'h3;
    localparam logic [3:0] PE4      = 4'h4;
    localparam logic [3:0] PE5      = 4'h5;
    localparam logic [3:0] PE6      = 4'h6;
    localparam logic [3:0] PE7      = 4'h7;
    localparam logic [3:0] PE8      = 4'h8;

    typedef enum logic [1:0] {
        OP_RD     = 2'b00,
        OP_WR     = 2'b01,
        OP_RD_RSP = 2'b10,
        OP_WR_ACK = 2'b11
    } op_e;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] src;
        op_e        op;
        logic [6:0] addr;
        logic [15:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_UP,
        ST_RX_DN,
        ST_CHECK,
        ST_MEM_WAIT,
        ST_TX_UP,
        ST_TX_DN
    } rsp_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_UP,
        TX_DN
    } tx_state_e;

    // Only RD and WR are requests a memory endpoint may serve.
    function automatic logic is_request(input op_e op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/noc_mem_responder_hs4_tx.sv
// Clocked 4-phase bundled-data transmitter. A load in idle captures the
// packet and raises out_req; out_req drops once out_ack is seen high, and the
// channel is free again after out_ack returns low. out_data holds its last
// value until the next load.
module hs4_tx
    import noc_mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack,
    output logic             busy
);

    tx_state_e state, state_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; an ack already high when entering TX_UP counts as the ack.
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: if (load)     state_nxt = TX_UP;
            TX_UP:   if (out_ack)  state_nxt = TX_DN;
            TX_DN:   if (!out_ack) state_nxt = TX_IDLE;
            default:               state_nxt = TX_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        out_req = (state == TX_UP);
        busy    = (state != TX_IDLE);
    end

    // Packet register, loaded only when the channel is idle.
    always_ff @(posedge clk) begin
        if (rst)                            out_data <= '0;
        else if (state == TX_IDLE && load)  out_data <= data;
    end

endmodule

// File: rtl/noc_mem_responder.sv
// Memory-side NoC endpoint: receives request packets over a 4-phase channel,
// performs the access on a synchronous SRAM port and returns read-data or
// write-ack packets to the requesting node.
module noc_mem_responder
    import noc_mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH      = 33,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 16,
    parameter logic [3:0]  MY_ADDR    = MEM_NODE,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned ACK_WRITES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ack,
    output logic              out_req,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        drop_cnt
);

    rsp_state_e state, state_nxt;
    pkt_t       req_q;
    pkt_t       rsp;
    logic [2:0] wait_cnt;
    logic       accept;
    logic       is_wr;
    logic       lat_done;
    logic       silent_wr;
    logic       latch_in;
    logic       mem_fire;
    logic       drop_inc;
    logic       tx_load;
    logic       tx_busy;

    assign accept    = (req_q.dest == MY_ADDR) && is_request(req_q.op);
    assign is_wr     = (req_q.op == OP_WR);
    assign lat_done  = (wait_cnt == 3'(MEM_LAT));
    assign silent_wr = is_wr && (ACK_WRITES == 0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the TX states track the transmitter's own phases.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (in_req)   state_nxt = ST_RX_UP;
            ST_RX_UP:    if (!in_req)  state_nxt = ST_RX_DN;
            ST_RX_DN:                  state_nxt = ST_CHECK;
            ST_CHECK:    state_nxt = accept ? ST_MEM_WAIT : ST_IDLE;
            ST_MEM_WAIT: if (lat_done) state_nxt = silent_wr ? ST_IDLE : ST_TX_UP;
            ST_TX_UP:    if (out_ack)  state_nxt = ST_TX_DN;
            ST_TX_DN:    if (!out_ack) state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Output and strobe decode, including the response packet assembly.
    always_comb begin
        in_ack   = (state == ST_RX_UP);
        latch_in = (state == ST_IDLE) && in_req;
        mem_fire = (state == ST_CHECK) && accept;
        drop_inc = (state == ST_CHECK) && !accept;
        tx_load  = (state == ST_MEM_WAIT) && lat_done && !silent_wr && !tx_busy;
        rsp      = '0;
        rsp.dest = req_q.src;
        rsp.src  = MY_ADDR;
        rsp.op   = is_wr ? OP_WR_ACK : OP_RD_RSP;
        rsp.addr = req_q.addr;
        rsp.data = is_wr ? req_q.data : mem_rdata;
    end

    // Request capture, SRAM strobes, latency counter and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (latch_in) req_q <= in_data;
            mem_en <= mem_fire;
            mem_we <= mem_fire && is_wr;
            if (mem_fire) begin
                mem_addr  <= req_q.addr;
                mem_wdata <= req_q.data;
            end
            if (state == ST_CHECK)         wait_cnt <= '0;
            else if (state == ST_MEM_WAIT) wait_cnt <= wait_cnt + 3'd1;
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    hs4_tx #(
        .WIDTH (WIDTH)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .data     (rsp),
        .out_req  (out_req),
        .out_data (out_data),
        .out_ack  (out_ack),
        .busy     (tx_busy)
    );

endmodule

// File: tb/tb_noc_mem_responder.sv
// Directed bench for noc_mem_responder: one instance with MEM_LAT=2 and write
// acks, one with MEM_LAT=1 and silent writes, each backed by a small SRAM model.
module tb_noc_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_req, in_ack, out_req, out_ack;
    logic [32:0] in_data, out_data;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [7:0]  drop_cnt;

    logic        b_in_req, b_in_ack, b_out_req, b_out_ack;
    logic [32:0] b_in_data, b_out_data;
    logic        b_mem_en, b_mem_we;
    logic [6:0]  b_mem_addr;
    logic [15:0] b_mem_wdata, b_mem_rdata;
    logic [7:0]  b_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    noc_mem_responder #(
        .MEM_LAT    (2),
        .ACK_WRITES (1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
    );

    noc_mem_responder #(
        .MEM_LAT    (1),
        .ACK_WRITES (0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_req(b_in_req), .in_data(b_in_data), .in_ack(b_in_ack),
        .out_req(b_out_req), .out_data(b_out_data), .out_ack(b_out_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .drop_cnt(b_drop_cnt)
    );

    // SRAM models: read data is valid only in the single cycle MEM_LAT after mem_en.
    logic [15:0] mem_a [128];
    logic [15:0] mem_b [128];
    logic [15:0] pa0 = 16'hDEAD, pa1 = 16'hDEAD, pb0 = 16'hDEAD;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
        pa0 <= (mem_en && !mem_we) ? mem_a[mem_addr] : 16'hDEAD;
        pa1 <= pa0;
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        pb0 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 16'hDEAD;
    end
    assign mem_rdata   = pa1;
    assign b_mem_rdata = pb0;

    // Event monitor, sampling 2 time units after each rising edge.
    int          men_cnt = 0, men_cyc = 0, oreq_cnt = 0, oreq_cyc = 0;
    logic        men_we = 1'b0, oreq_prev = 1'b0;
    logic [6:0]  men_addr = '0;
    logic [15:0] men_wdata = '0;
    int          b_men_cnt = 0, b_men_cyc = 0, b_oreq_cnt = 0, b_oreq_cyc = 0;
    logic        b_men_we = 1'b0, b_oreq_prev = 1'b0;
    logic [6:0]  b_men_addr = '0;
    logic [15:0] b_men_wdata = '0;
    always @(posedge clk) begin
        #2;
        if (mem_en) begin
            men_cnt++; men_cyc = cyc; men_we = mem_we; men_addr = mem_addr; men_wdata = mem_wdata;
        end
        if (out_req && !oreq_prev) begin oreq_cnt++; oreq_cyc = cyc; end
        oreq_prev = out_req;
        if (b_mem_en) begin
            b_men_cnt++; b_men_cyc = cyc; b_men_we = b_mem_we; b_men_addr = b_mem_addr; b_men_wdata = b_mem_wdata;
        end
        if (b_out_req && !b_oreq_prev) begin b_oreq_cnt++; b_oreq_cyc = cyc; end
        b_oreq_prev = b_out_req;
    end

    // Drive one request through the inbound 4-phase handshake.
    task automatic send_pkt(input bit to_b, input logic [32:0] p, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        if (to_b) begin b_in_data = p; b_in_req = 1'b1; end
        else      begin in_data = p;   in_req = 1'b1;   end
        n = 0;
        while (!(to_b ? b_in_ack : in_ack) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) ok = 1'b0;
        if (to_b) b_in_req = 1'b0; else in_req = 1'b0;
        n = 0;
        while ((to_b ? b_in_ack : in_ack) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) ok = 1'b0;
    endtask

    // Accept one response through the outbound 4-phase handshake.
    task automatic recv_rsp(input bit from_b, output logic [32:0] d, output bit ok);
        int n;
        ok = 1'b1;
        d  = '0;
        n  = 0;
        while (!(from_b ? b_out_req : out_req) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin ok = 1'b0; return; end
        d = from_b ? b_out_data : out_data;
        if (from_b) b_out_ack = 1'b1; else out_ack = 1'b1;
        n = 0;
        while ((from_b ? b_out_req : out_req) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) ok = 1'b0;
        if (from_b) b_out_ack = 1'b0; else out_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ack !== 1'b0 || out_req !== 1'b0) begin n_bad++;
            $display("FAIL reset_hs: in_ack=%b out_req=%b want 0 0", in_ack, out_req); end
        n_cmp++; if (out_data !== 33'h0) begin n_bad++;
            $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 25'h0) begin n_bad++;
            $display("FAIL reset_mem: en=%b we=%b addr=%h wdata=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++;
            $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        bit ok; logic [32:0] d; int m0;
        m0 = men_cnt;
        send_pkt(1'b0, {4'b1101, 4'b0010, 2'b01, 7'h05, 16'hBEEF}, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_in_hs: ok=%b want 1", ok); end
        recv_rsp(1'b0, d, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_out_hs: ok=%b want 1", ok); end
        n_cmp++; if (d !== {4'b0010, 4'b1101, 2'b11, 7'h05, 16'hBEEF}) begin n_bad++;
            $display("FAIL wr_ack_pkt: got %h want %h", d, {4'b0010, 4'b1101, 2'b11, 7'h05, 16'hBEEF}); end
        n_cmp++; if (men_cnt !== m0 + 1 || men_we !== 1'b1 || men_addr !== 7'h05 || men_wdata !== 16'hBEEF) begin n_bad++;
            $display("FAIL wr_mem: pulses=%0d we=%b addr=%h wdata=%h want %0d 1 05 beef", men_cnt - m0, men_we, men_addr, men_wdata, 1); end
        n_cmp++; if (mem_a[5] !== 16'hBEEF) begin n_bad++;
            $display("FAIL wr_sram: got %h want beef", mem_a[5]); end
    endtask

    task automatic test_read();
        bit ok; logic [32:0] d;
        send_pkt(1'b0, {4'b1101, 4'b0010, 2'b00, 7'h05, 16'h0000}, ok);
        recv_rsp(1'b0, d, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_hs: ok=%b want 1", ok); end
        n_cmp++; if (d !== {4'b0010, 4'b1101, 2'b10, 7'h05, 16'hBEEF}) begin n_bad++;
            $display("FAIL rd_rsp_pkt: got %h want %h", d, {4'b0010, 4'b1101, 2'b10, 7'h05, 16'hBEEF}); end
        n_cmp++; if (oreq_cyc - men_cyc !== 3) begin n_bad++;
            $display("FAIL rd_latency: got %0d want 3", oreq_cyc - men_cyc); end
        n_cmp++; if (men_we !== 1'b0 || men_addr !== 7'h05) begin n_bad++;
            $display("FAIL rd_mem: we=%b addr=%h want 0 05", men_we, men_addr); end
    endtask

    task automatic test_misroute();
        bit ok; int m0, o0;
        m0 = men_cnt; o0 = oreq_cnt;
        send_pkt(1'b0, {4'b0100, 4'b0010, 2'b00, 7'h05, 16'h0000}, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mis_hs: ok=%b want 1", ok); end
        n_cmp++; if (men_cnt !== m0 || oreq_cnt !== o0) begin n_bad++;
            $display("FAIL mis_quiet: mem_en=%0d out_req=%0d want 0 0", men_cnt - m0, oreq_cnt - o0); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL mis_drop1: got %0d want 1", drop_cnt); end
        send_pkt(1'b0, {4'b1101, 4'b0010, 2'b10, 7'h05, 16'h1111}, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (drop_cnt !== 8'd2 || men_cnt !== m0) begin n_bad++;
            $display("FAIL mis_drop2: drop=%0d mem_en=%0d want 2 0", drop_cnt, men_cnt - m0); end
    endtask

    task automatic test_backpressure();
        bit ok; logic [32:0] d, d0; int n, bad_req, bad_data, early;
        bad_req = 0; bad_data = 0; early = 0;
        send_pkt(1'b0, {4'b1101, 4'b0010, 2'b00, 7'h05, 16'h0000}, ok);
        n = 0;
        while (!out_req && n < 100) begin @(negedge clk); n++; end
        d0 = out_data;
        n_cmp++; if (d0 !== {4'b0010, 4'b1101, 2'b10, 7'h05, 16'hBEEF}) begin n_bad++;
            $display("FAIL bp_pkt: got %h want %h", d0, {4'b0010, 4'b1101, 2'b10, 7'h05, 16'hBEEF}); end
        in_data = {4'b1101, 4'b0011, 2'b01, 7'h06, 16'h1234};
        in_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_req !== 1'b1) bad_req++;
            if (out_data !== d0)  bad_data++;
            if (in_ack !== 1'b0)  early++;
        end
        n_cmp++; if (bad_req !== 0 || bad_data !== 0) begin n_bad++;
            $display("FAIL bp_hold: req_drops=%0d data_changes=%0d want 0 0", bad_req, bad_data); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL bp_no_in_ack: got %0d cycles want 0", early); end
        out_ack = 1'b1;
        n = 0;
        while (out_req && n < 100) begin @(negedge clk); n++; end
        out_ack = 1'b0;
        n = 0;
        while (!in_ack && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (in_ack !== 1'b1) begin n_bad++; $display("FAIL bp_in_ack_later: got %b want 1", in_ack); end
        in_req = 1'b0;
        n = 0;
        while (in_ack && n < 100) begin @(negedge clk); n++; end
        recv_rsp(1'b0, d, ok);
        n_cmp++; if (d !== {4'b0011, 4'b1101, 2'b11, 7'h06, 16'h1234} || ok !== 1'b1) begin n_bad++;
            $display("FAIL bp_second: got %h ok=%b want %h", d, ok, {4'b0011, 4'b1101, 2'b11, 7'h06, 16'h1234}); end
        n_cmp++; if (mem_a[6] !== 16'h1234) begin n_bad++; $display("FAIL bp_sram: got %h want 1234", mem_a[6]); end
    endtask

    task automatic test_reset_mid_tx();
        bit ok; logic [32:0] d; int n, o0;
        send_pkt(1'b0, {4'b1101, 4'b0100, 2'b00, 7'h06, 16'h0000}, ok);
        n = 0;
        while (!out_req && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (out_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_tx: out_req=%b want 1", out_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_req !== 1'b0 || out_data !== 33'h0 || in_ack !== 1'b0) begin n_bad++;
            $display("FAIL rst_mid_hs: out_req=%b out_data=%h in_ack=%b want 0 0 0", out_req, out_data, in_ack); end
        n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 25'h0 || drop_cnt !== 8'd0) begin n_bad++;
            $display("FAIL rst_mid_mem: en=%b we=%b addr=%h wdata=%h drop=%0d want all 0", mem_en, mem_we, mem_addr, mem_wdata, drop_cnt); end
        o0 = oreq_cnt;
        repeat (8) @(negedge clk);
        n_cmp++; if (oreq_cnt !== o0 || out_req !== 1'b0) begin n_bad++;
            $display("FAIL rst_abandon: out_req rises=%0d want 0", oreq_cnt - o0); end
        send_pkt(1'b0, {4'b1101, 4'b0001, 2'b00, 7'h05, 16'h0000}, ok);
        recv_rsp(1'b0, d, ok);
        n_cmp++; if (d !== {4'b0001, 4'b1101, 2'b10, 7'h05, 16'hBEEF} || ok !== 1'b1) begin n_bad++;
            $display("FAIL rst_then_rd: got %h ok=%b want %h", d, ok, {4'b0001, 4'b1101, 2'b10, 7'h05, 16'hBEEF}); end
    endtask

    task automatic test_saturation();
        bit ok; int bad_hs;
        logic [3:0] src;
        bad_hs = 0;
        for (int i = 0; i < 255; i++) begin
            src = 4'(i);
            send_pkt(1'b0, {4'b0000, src, 2'b00, 7'h01, 16'h0000}, ok);
            if (!ok) bad_hs++;
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (drop_cnt !== 8'd255 || bad_hs !== 0) begin n_bad++;
            $display("FAIL sat_255: drop=%0d hs_errors=%0d want 255 0", drop_cnt, bad_hs); end
        for (int i = 0; i < 5; i++) begin
            send_pkt(1'b0, {4'b0111, 4'b0001, 2'b01, 7'h02, 16'h0000}, ok);
            if (!ok) bad_hs++;
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (drop_cnt !== 8'd255 || bad_hs !== 0) begin n_bad++;
            $display("FAIL sat_hold: drop=%0d hs_errors=%0d want 255 0", drop_cnt, bad_hs); end
    endtask

    task automatic test_silent_write();
        bit ok; logic [32:0] d; int m0, o0;
        m0 = b_men_cnt; o0 = b_oreq_cnt;
        send_pkt(1'b1, {4'b1101, 4'b0001, 2'b01, 7'h7F, 16'hA5A5}, ok);
        repeat (20) @(negedge clk);
        n_cmp++; if (b_men_cnt !== m0 + 1 || b_men_we !== 1'b1 || b_men_addr !== 7'h7F || b_men_wdata !== 16'hA5A5) begin n_bad++;
            $display("FAIL nack_wr_mem: pulses=%0d we=%b addr=%h wdata=%h want 1 1 7f a5a5", b_men_cnt - m0, b_men_we, b_men_addr, b_men_wdata); end
        n_cmp++; if (b_oreq_cnt !== o0 || b_out_req !== 1'b0) begin n_bad++;
            $display("FAIL nack_wr_quiet: out_req rises=%0d want 0", b_oreq_cnt - o0); end
        n_cmp++; if (mem_b[127] !== 16'hA5A5) begin n_bad++; $display("FAIL nack_sram: got %h want a5a5", mem_b[127]); end
        send_pkt(1'b1, {4'b1101, 4'b0001, 2'b00, 7'h7F, 16'h0000}, ok);
        recv_rsp(1'b1, d, ok);
        n_cmp++; if (d !== {4'b0001, 4'b1101, 2'b10, 7'h7F, 16'hA5A5} || ok !== 1'b1) begin n_bad++;
            $display("FAIL nack_rd: got %h ok=%b want %h", d, ok, {4'b0001, 4'b1101, 2'b10, 7'h7F, 16'hA5A5}); end
        n_cmp++; if (b_oreq_cyc - b_men_cyc !== 2) begin n_bad++;
            $display("FAIL nack_rd_latency: got %0d want 2", b_oreq_cyc - b_men_cyc); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_req = 1'b0;   in_data = '0;   out_ack = 1'b0;
        b_in_req = 1'b0; b_in_data = '0; b_out_ack = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_misroute();
        test_backpressure();
        test_reset_mid_tx();
        test_saturation();
        test_silent_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
